// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing generator.
// Walks a pixel clock across a frame of display, front porch, sync and back porch
// segments (horizontally within a line, vertically within a frame). The pixel
// source sees a combinational request plus coordinates. Sync, blank and colour
// outputs are delayed to line up with the source's fixed read latency.
module vga_timing_gen #(
    parameter int RGB_WIDTH   = 10,
    parameter int H_DISPLAY   = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_DISPLAY   = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter bit HSYNC_POL   = 1'b0,
    parameter bit VSYNC_POL   = 1'b0,
    parameter int PIX_LATENCY = 2,
    localparam int H_TOTAL    = H_DISPLAY + H_FRONT + H_SYNC + H_BACK,
    localparam int V_TOTAL    = V_DISPLAY + V_FRONT + V_SYNC + V_BACK,
    localparam int XW         = $clog2(H_TOTAL),
    localparam int YW         = $clog2(V_TOTAL)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    output logic                 pix_req,
    output logic [XW-1:0]        pix_x,
    output logic [YW-1:0]        pix_y,
    input  logic [RGB_WIDTH-1:0] pix_r,
    input  logic [RGB_WIDTH-1:0] pix_g,
    input  logic [RGB_WIDTH-1:0] pix_b,
    output logic [RGB_WIDTH-1:0] r,
    output logic [RGB_WIDTH-1:0] g,
    output logic [RGB_WIDTH-1:0] b,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 blank_n,
    output logic                 sync_n,
    output logic                 frame_start,
    output logic                 line_start
);

    // Segment boundaries are held one bit wider than the counters so that an
    // end boundary equal to the total still fits and compares correctly.
    localparam logic [XW:0]   H_DISP_END = (XW+1)'(H_DISPLAY);
    localparam logic [XW:0]   H_SYNC_BEG = (XW+1)'(H_DISPLAY + H_FRONT);
    localparam logic [XW:0]   H_SYNC_END = (XW+1)'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [YW:0]   V_DISP_END = (YW+1)'(V_DISPLAY);
    localparam logic [YW:0]   V_SYNC_BEG = (YW+1)'(V_DISPLAY + V_FRONT);
    localparam logic [YW:0]   V_SYNC_END = (YW+1)'(V_DISPLAY + V_FRONT + V_SYNC);
    localparam logic [XW-1:0] H_LAST     = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0] V_LAST     = YW'(V_TOTAL - 1);

    // Each pipeline stage carries {pix_req, vsync_active, hsync_active}.
    localparam int SW  = 3;
    localparam int SRW = SW * (PIX_LATENCY + 1);

    logic [XW-1:0]        h_cnt_q, h_cnt_d;
    logic [YW-1:0]        v_cnt_q, v_cnt_d;
    logic                 run_s;
    logic [XW:0]          h_ext_s;
    logic [YW:0]          v_ext_s;
    logic                 h_disp_s, v_disp_s;
    logic                 hs_raw_s, vs_raw_s, req_raw_s;
    logic                 line_first_s;
    logic [SW-1:0]        raw_s;
    logic [SRW-1:0]       chain_s;
    logic [SW-1:0]        dly_s;

    logic                 hsync_q, hsync_d;
    logic                 vsync_q, vsync_d;
    logic                 blank_n_q, blank_n_d;
    logic [RGB_WIDTH-1:0] r_q, r_d;
    logic [RGB_WIDTH-1:0] g_q, g_d;
    logic [RGB_WIDTH-1:0] b_q, b_d;

    // Markers and the pixel request are suppressed while reset is held so the
    // reset state shows no spurious frame_start at coordinate (0,0).
    assign run_s = enable & rst_n;

    // Next counter values: run while enabled, park at (0,0) while disabled.
    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (!enable) begin
            h_cnt_d = '0;
            v_cnt_d = '0;
        end else if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            if (v_cnt_q == V_LAST) begin
                v_cnt_d = '0;
            end else begin
                v_cnt_d = v_cnt_q + YW'(1);
            end
        end else begin
            h_cnt_d = h_cnt_q + XW'(1);
        end
    end

    // Horizontal and vertical position counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    // Segment decode from the current counter state.
    always_comb begin
        h_ext_s      = {1'b0, h_cnt_q};
        v_ext_s      = {1'b0, v_cnt_q};
        h_disp_s     = (h_ext_s < H_DISP_END);
        v_disp_s     = (v_ext_s < V_DISP_END);
        hs_raw_s     = run_s & (h_ext_s >= H_SYNC_BEG) & (h_ext_s < H_SYNC_END);
        vs_raw_s     = run_s & (v_ext_s >= V_SYNC_BEG) & (v_ext_s < V_SYNC_END);
        req_raw_s    = run_s & h_disp_s & v_disp_s;
        line_first_s = run_s & (h_cnt_q == '0);
    end

    assign pix_req     = req_raw_s;
    assign pix_x       = h_cnt_q;
    assign pix_y       = v_cnt_q;
    assign line_start  = line_first_s;
    assign frame_start = line_first_s & (v_cnt_q == '0);
    assign sync_n      = 1'b0;

    // Slice 0 of the chain is the undelayed decode; slice k is k clocks old.
    assign raw_s          = {req_raw_s, vs_raw_s, hs_raw_s};
    assign chain_s[SW-1:0] = raw_s;

    generate
        if (PIX_LATENCY > 0) begin : g_dly
            logic [SW*PIX_LATENCY-1:0] dly_q, dly_d;

            // Shift every slice up by one stage; the newest decode enters at the bottom.
            always_comb begin
                dly_d = chain_s[SW*PIX_LATENCY-1:0];
            end

            // Latency-matching delay line for sync and request.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dly_q <= '0;
                end else begin
                    dly_q <= dly_d;
                end
            end

            assign chain_s[SRW-1:SW] = dly_q;
        end
    endgenerate

    assign dly_s = chain_s[SRW-1 -: SW];

    // Output stage: polarity, blanking and colour gating from the delayed decode.
    always_comb begin
        hsync_d   = dly_s[0] ? HSYNC_POL : ~HSYNC_POL;
        vsync_d   = dly_s[1] ? VSYNC_POL : ~VSYNC_POL;
        blank_n_d = dly_s[2];
        if (dly_s[2]) begin
            r_d = pix_r;
            g_d = pix_g;
            b_d = pix_b;
        end else begin
            r_d = '0;
            g_d = '0;
            b_d = '0;
        end
    end

    // Registered DAC-side outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_q   <= ~HSYNC_POL;
            vsync_q   <= ~VSYNC_POL;
            blank_n_q <= 1'b0;
            r_q       <= '0;
            g_q       <= '0;
            b_q       <= '0;
        end else begin
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
            blank_n_q <= blank_n_d;
            r_q       <= r_d;
            g_q       <= g_d;
            b_q       <= b_d;
        end
    end

    assign hsync   = hsync_q;
    assign vsync   = vsync_q;
    assign blank_n = blank_n_q;
    assign r       = r_q;
    assign g       = g_q;
    assign b       = b_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two small-raster instances (active-low and
// active-high sync) and one default 640x480 instance, checked every cycle
// against a frame-position model, plus hand-computed timing points.
module tb_vga_timing_gen;

    localparam int LAT = 2;

    logic       clk;
    logic       rst_n;
    logic       en_ab;
    logic       en_c;

    logic [2:0] x_a, y_a, x_b, y_b;
    logic [9:0] x_c, y_c;
    logic [9:0] pr_a, pg_a, pb_a;
    logic [9:0] pr_c, pg_c, pb_c;
    logic [9:0] r_a, g_a, b_a, r_b, g_b, b_b, r_c, g_c, b_c;
    logic req_a, hs_a, vs_a, bn_a, sn_a, fs_a, ls_a;
    logic req_b, hs_b, vs_b, bn_b, sn_b, fs_b, ls_b;
    logic req_c, hs_c, vs_c, bn_c, sn_c, fs_c, ls_c;

    int n_tests = 0;
    int n_fail  = 0;

    vga_timing_gen #(
        .H_DISPLAY(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_DISPLAY(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .PIX_LATENCY(LAT)
    ) u_a (
        .clk(clk), .rst_n(rst_n), .enable(en_ab), .pix_req(req_a),
        .pix_x(x_a), .pix_y(y_a), .pix_r(pr_a), .pix_g(pg_a), .pix_b(pb_a),
        .r(r_a), .g(g_a), .b(b_a), .hsync(hs_a), .vsync(vs_a),
        .blank_n(bn_a), .sync_n(sn_a), .frame_start(fs_a), .line_start(ls_a)
    );

    vga_timing_gen #(
        .H_DISPLAY(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_DISPLAY(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .PIX_LATENCY(LAT)
    ) u_b (
        .clk(clk), .rst_n(rst_n), .enable(en_ab), .pix_req(req_b),
        .pix_x(x_b), .pix_y(y_b), .pix_r(pr_a), .pix_g(pg_a), .pix_b(pb_a),
        .r(r_b), .g(g_b), .b(b_b), .hsync(hs_b), .vsync(vs_b),
        .blank_n(bn_b), .sync_n(sn_b), .frame_start(fs_b), .line_start(ls_b)
    );

    vga_timing_gen u_c (
        .clk(clk), .rst_n(rst_n), .enable(en_c), .pix_req(req_c),
        .pix_x(x_c), .pix_y(y_c), .pix_r(pr_c), .pix_g(pg_c), .pix_b(pb_c),
        .r(r_c), .g(g_c), .b(b_c), .hsync(hs_c), .vsync(vs_c),
        .blank_n(bn_c), .sync_n(sn_c), .frame_start(fs_c), .line_start(ls_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    typedef struct {
        int req;
        int hs;
        int vs;
        int pr;
        int pg;
        int pb;
    } rec_t;

    int p_hd [3] = '{4, 4, 640};
    int p_hf [3] = '{1, 1, 16};
    int p_hs [3] = '{2, 2, 96};
    int p_hb [3] = '{1, 1, 48};
    int p_vd [3] = '{3, 3, 480};
    int p_vf [3] = '{1, 1, 10};
    int p_vs [3] = '{1, 1, 2};
    int p_vb [3] = '{1, 1, 33};
    int p_pol[3] = '{0, 1, 0};

    int   tick [3];
    rec_t hist [3][8];
    rec_t zero_rec = '{0, 0, 0, 0, 0, 0};

    function automatic int ht(input int i);
        return p_hd[i] + p_hf[i] + p_hs[i] + p_hb[i];
    endfunction

    function automatic int vt(input int i);
        return p_vd[i] + p_vf[i] + p_vs[i] + p_vb[i];
    endfunction

    function automatic int en_of(input int i);
        return (i == 2) ? int'(en_c) : int'(en_ab);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // Advance the frame position by one clock and log what the decode was.
    task automatic model_step(input int i);
        int en, h, v, hsb, vsb;
        rec_t rr;
        if (rst_n !== 1'b1) begin
            tick[i] = 0;
            for (int k = 0; k < 8; k++) hist[i][k] = zero_rec;
        end else begin
            en  = en_of(i);
            h   = tick[i] % ht(i);
            v   = tick[i] / ht(i);
            hsb = p_hd[i] + p_hf[i];
            vsb = p_vd[i] + p_vf[i];
            rr.req = (en != 0 && h < p_hd[i] && v < p_vd[i]) ? 1 : 0;
            rr.hs  = (en != 0 && h >= hsb && h < hsb + p_hs[i]) ? 1 : 0;
            rr.vs  = (en != 0 && v >= vsb && v < vsb + p_vs[i]) ? 1 : 0;
            rr.pr  = (i == 2) ? int'(pr_c) : int'(pr_a);
            rr.pg  = (i == 2) ? int'(pg_c) : int'(pg_a);
            rr.pb  = (i == 2) ? int'(pb_c) : int'(pb_a);
            for (int k = 7; k > 0; k--) hist[i][k] = hist[i][k-1];
            hist[i][0] = rr;
            tick[i] = (en != 0) ? (tick[i] + 1) % (ht(i) * vt(i)) : 0;
        end
    endtask

    task automatic chk_inst(input int i, input int px, input int py, input int rq,
                            input int ls, input int fs, input int hs, input int vs,
                            input int bn, input int sn, input int r, input int g, input int b);
        int en, h, v, pol;
        int e_px, e_py, e_rq, e_ls, e_fs, e_hs, e_vs, e_bn, e_r, e_g, e_b;
        rec_t d;
        pol = p_pol[i];
        if (rst_n !== 1'b1) begin
            e_px = 0; e_py = 0; e_rq = 0; e_ls = 0; e_fs = 0;
            e_hs = 1 - pol; e_vs = 1 - pol; e_bn = 0; e_r = 0; e_g = 0; e_b = 0;
        end else begin
            en   = en_of(i);
            h    = tick[i] % ht(i);
            v    = tick[i] / ht(i);
            d    = hist[i][LAT];
            e_px = h;
            e_py = v;
            e_rq = (en != 0 && h < p_hd[i] && v < p_vd[i]) ? 1 : 0;
            e_ls = (en != 0 && h == 0) ? 1 : 0;
            e_fs = (en != 0 && tick[i] == 0) ? 1 : 0;
            e_hs = (d.hs != 0) ? pol : 1 - pol;
            e_vs = (d.vs != 0) ? pol : 1 - pol;
            e_bn = d.req;
            e_r  = (d.req != 0) ? hist[i][0].pr : 0;
            e_g  = (d.req != 0) ? hist[i][0].pg : 0;
            e_b  = (d.req != 0) ? hist[i][0].pb : 0;
        end
        chk($sformatf("i%0d pix_x", i), px, e_px);
        chk($sformatf("i%0d pix_y", i), py, e_py);
        chk($sformatf("i%0d pix_req", i), rq, e_rq);
        chk($sformatf("i%0d line_start", i), ls, e_ls);
        chk($sformatf("i%0d frame_start", i), fs, e_fs);
        chk($sformatf("i%0d hsync", i), hs, e_hs);
        chk($sformatf("i%0d vsync", i), vs, e_vs);
        chk($sformatf("i%0d blank_n", i), bn, e_bn);
        chk($sformatf("i%0d sync_n", i), sn, 0);
        chk($sformatf("i%0d r", i), r, e_r);
        chk($sformatf("i%0d g", i), g, e_g);
        chk($sformatf("i%0d b", i), b, e_b);
    endtask

    // Model update on every active edge.
    initial begin
        for (int i = 0; i < 3; i++) begin
            tick[i] = 0;
            for (int k = 0; k < 8; k++) hist[i][k] = zero_rec;
        end
        forever begin
            @(posedge clk);
            for (int i = 0; i < 3; i++) model_step(i);
        end
    end

    // Every-cycle comparison on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            chk_inst(0, int'(x_a), int'(y_a), int'(req_a), int'(ls_a), int'(fs_a), int'(hs_a),
                     int'(vs_a), int'(bn_a), int'(sn_a), int'(r_a), int'(g_a), int'(b_a));
            chk_inst(1, int'(x_b), int'(y_b), int'(req_b), int'(ls_b), int'(fs_b), int'(hs_b),
                     int'(vs_b), int'(bn_b), int'(sn_b), int'(r_b), int'(g_b), int'(b_b));
            chk_inst(2, int'(x_c), int'(y_c), int'(req_c), int'(ls_c), int'(fs_c), int'(hs_c),
                     int'(vs_c), int'(bn_c), int'(sn_c), int'(r_c), int'(g_c), int'(b_c));
        end
    end

    // Pixel source for the small instances: returns pix_x two clocks after request.
    int s1, s2;
    initial begin
        s1 = 0; s2 = 0;
        pr_a = 10'd0; pg_a = 10'h3FF; pb_a = 10'd5;
        forever begin
            @(negedge clk);
            s2 = s1;
            s1 = int'(x_a);
            @(posedge clk);
            #1;
            pr_a = 10'(s2);
            pg_a = ~pr_a;
            pb_a = pr_a + 10'd5;
        end
    end

    // ---------------- directed stimulus and literal checks ----------------
    int cnt_fs_a, cnt_hs_a, cnt_vs_a, cnt_ls_c, cnt_fs_c, cnt_bn_c, cnt_hs_c;
    int k;

    initial begin
        rst_n = 1'b0;
        en_ab = 1'b1;
        en_c  = 1'b1;
        pr_c  = 10'h155;
        pg_c  = 10'h2AA;
        pb_c  = 10'h0F0;
        cnt_fs_a = 0; cnt_hs_a = 0; cnt_vs_a = 0;
        cnt_ls_c = 0; cnt_fs_c = 0; cnt_bn_c = 0; cnt_hs_c = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst hsync A", int'(hs_a), 1);
        chk("rst hsync B", int'(hs_b), 0);
        chk("rst vsync B", int'(vs_b), 0);
        chk("rst blank A", int'(bn_a), 0);
        chk("rst frame_start A", int'(fs_a), 0);
        chk("rst line_start C", int'(ls_c), 0);

        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int c = 0; c <= 1700; c++) begin
            @(negedge clk);
            if (c == 0 || c == 48) chk($sformatf("A frame_start c%0d", c), int'(fs_a), 1);
            if (c >= 1 && c <= 47 && fs_a) cnt_fs_a++;
            if (c >= 3 && c <= 6) begin
                chk($sformatf("A blank c%0d", c), int'(bn_a), 1);
                chk($sformatf("A r align c%0d", c), int'(r_a), c - 3);
            end
            if (c == 2 || c == 7) begin
                chk($sformatf("A blank c%0d", c), int'(bn_a), 0);
                chk($sformatf("A r zero c%0d", c), int'(r_a), 0);
            end
            if (c == 7 || c == 10) chk($sformatf("A hsync c%0d", c), int'(hs_a), 1);
            if (c == 8 || c == 9)  chk($sformatf("A hsync c%0d", c), int'(hs_a), 0);
            if (c == 8) chk("B hsync c8", int'(hs_b), 1);
            if (c == 7) chk("B hsync c7", int'(hs_b), 0);
            if (c == 34 || c == 43) chk($sformatf("A vsync c%0d", c), int'(vs_a), 1);
            if (c == 35 || c == 42) chk($sformatf("A vsync c%0d", c), int'(vs_a), 0);
            if (c == 35) chk("B vsync c35", int'(vs_b), 1);
            if (c >= 3 && c <= 50 && !hs_a) cnt_hs_a++;
            if (c <= 47 && !vs_a) cnt_vs_a++;
            if (c == 0) chk("C frame_start c0", int'(fs_c), 1);
            if (c >= 1 && fs_c) cnt_fs_c++;
            if (ls_c) cnt_ls_c++;
            if (c <= 1602 && bn_c) cnt_bn_c++;
            if (c <= 1602 && !hs_c) cnt_hs_c++;
            if (c == 3 || c == 642) chk($sformatf("C r c%0d", c), int'(r_c), 10'h155);
            if (c == 643) chk("C blank c643", int'(bn_c), 0);
        end
        chk("A extra frame_start", cnt_fs_a, 0);
        chk("A hsync low clocks", cnt_hs_a, 12);
        chk("A vsync low clocks", cnt_vs_a, 8);
        chk("C extra frame_start", cnt_fs_c, 0);
        chk("C line_start count", cnt_ls_c, 3);
        chk("C blank_n high clocks", cnt_bn_c, 1280);
        chk("C hsync low clocks", cnt_hs_c, 192);

        // Enable drop at h=2, v=1.
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(x_a == 3'd2 && y_a == 3'd1) && k < 100);
        chk("wait h2v1 timeout", (x_a == 3'd2 && y_a == 3'd1) ? 1 : 0, 1);
        #1 en_ab = 1'b0;
        #1 chk("drop pix_req", int'(req_a), 0);
        @(negedge clk);
        chk("drop pix_x", int'(x_a), 0);
        chk("drop pix_y", int'(y_a), 0);
        @(negedge clk);
        chk("drop blank d2", int'(bn_a), 1);
        @(negedge clk);
        chk("drop blank d3", int'(bn_a), 0);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #2 en_ab = 1'b1;
        @(negedge clk);
        chk("reenable frame_start", int'(fs_a), 1);
        chk("reenable pix_x", int'(x_a), 0);

        // Async reset between edges while hsync is active.
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(x_a == 3'd1 && hs_a == 1'b0) && k < 100);
        chk("wait hsync timeout", (x_a == 3'd1 && hs_a == 1'b0) ? 1 : 0, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async pix_x", int'(x_a), 0);
        chk("async pix_y", int'(y_a), 0);
        chk("async hsync A", int'(hs_a), 1);
        chk("async hsync B", int'(hs_b), 0);
        chk("async blank", int'(bn_a), 0);
        chk("async r", int'(r_a), 0);
        chk("async frame_start", int'(fs_a), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("release pix_x", int'(x_a), 0);
        chk("release pix_y", int'(y_a), 0);
        chk("release frame_start", int'(fs_a), 1);
        repeat (60) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
